// File: rtl/aes_pkg.sv
// Shared AES helpers: GF(2^8) arithmetic, S-boxes, rcon table and core FSM states.
// S-boxes are computed (GF inverse plus affine map) rather than tabulated.
package aes_pkg;

   localparam int unsigned NUM_ROUNDS = 10;

   typedef enum logic [1:0] {IDLE, KEXP, ROUND, DONE} state_t;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = '0;
      x = a;
      for (int unsigned i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // Multiplicative inverse as a^254; maps 0 to 0 as AES requires.
   function automatic logic [7:0] ginv(input logic [7:0] a);
      logic [7:0] p;
      logic [7:0] r;
      p = a;
      r = 8'h01;
      for (int unsigned i = 1; i < 8; i++) begin
         p = gmul(p, p);
         r = gmul(r, p);
      end
      return r;
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] b;
      b = ginv(x);
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] x);
      logic [7:0] t;
      t = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
      return ginv(t);
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] i);
      case (i)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [31:0] rot_word(input logic [31:0] w);
      return {w[23:0], w[31:24]};
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey, then InvMixColumns
// unless last_round is set.
module aes_inv_round
   import aes_pkg::*;
(
   input  logic [127:0] state_in,
   input  logic [127:0] rk,
   input  logic         last_round,
   output logic [127:0] state_out
);

   logic [127:0] sr;
   logic [127:0] ark;
   logic [127:0] mix;
   logic [7:0]   a0, a1, a2, a3;

   always_comb begin
      sr  = '0;
      ark = '0;
      mix = '0;
      a0  = '0;
      a1  = '0;
      a2  = '0;
      a3  = '0;
      // Byte (row r, column c) sits at index 4*c+r; row r comes from column c-r.
      for (int unsigned c = 0; c < 4; c++) begin
         for (int unsigned r = 0; r < 4; r++) begin
            sr[127 - 8*(4*c + r) -: 8] = inv_sbox(state_in[127 - 8*(4*((c + 4 - r) % 4) + r) -: 8]);
         end
      end
      ark = sr ^ rk;
      for (int unsigned c = 0; c < 4; c++) begin
         a0 = ark[127 - 32*c -: 8];
         a1 = ark[119 - 32*c -: 8];
         a2 = ark[111 - 32*c -: 8];
         a3 = ark[103 - 32*c -: 8];
         mix[127 - 32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
         mix[119 - 32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
         mix[111 - 32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
         mix[103 - 32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
      end
      state_out = last_round ? ark : mix;
   end

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES-128 decryption core, one inverse round per clock, round keys derived on the fly.
// Optional last-key cache enabled by defining AES_INV_KEY_CACHE_EN.
module aes_inv_cipher_iter
   import aes_pkg::*;
#(
   parameter int unsigned NR = NUM_ROUNDS
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] ct_in,
   input  logic [127:0] key_in,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] pt_out,
   output logic         busy
);

   state_t       fsm_q, fsm_d;
   logic [127:0] blk_q;
   logic [127:0] key_q;
   logic [127:0] pt_q;
   logic [3:0]   rnd_q;
   logic [127:0] fwd_rk;
   logic [127:0] inv_rk;
   logic [127:0] round_out;
   logic [127:0] hit_rk;
   logic         cache_hit;

   function automatic logic [127:0] fwd_step(input logic [127:0] k, input logic [3:0] i);
      logic [31:0] w0, w1, w2, w3;
      w0 = k[127:96] ^ sub_word(rot_word(k[31:0])) ^ {rcon(i), 24'h0};
      w1 = k[95:64] ^ w0;
      w2 = k[63:32] ^ w1;
      w3 = k[31:0] ^ w2;
      return {w0, w1, w2, w3};
   endfunction

   function automatic logic [127:0] inv_step(input logic [127:0] k, input logic [3:0] i);
      logic [31:0] p0, p1, p2, p3;
      p3 = k[31:0] ^ k[63:32];
      p2 = k[63:32] ^ k[95:64];
      p1 = k[95:64] ^ k[127:96];
      p0 = k[127:96] ^ sub_word(rot_word(p3)) ^ {rcon(i), 24'h0};
      return {p0, p1, p2, p3};
   endfunction

   // rnd_q counts 1..NR during KEXP and NR-1..0 during ROUND.
   assign fwd_rk = fwd_step(key_q, rnd_q);
   assign inv_rk = inv_step(key_q, rnd_q + 4'd1);

   aes_inv_round u_round (
      .state_in   (blk_q),
      .rk         (inv_rk),
      .last_round (rnd_q == 4'd0),
      .state_out  (round_out)
   );

`ifdef AES_INV_KEY_CACHE_EN
   logic [127:0] cache_key_q;
   logic [127:0] cache_rk_q;
   logic         cache_vld_q;

   assign cache_hit = cache_vld_q && (key_in == cache_key_q);
   assign hit_rk    = cache_rk_q;

   // The original key is latched at accept because key_q is overwritten during KEXP.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cache_key_q <= '0;
         cache_rk_q  <= '0;
         cache_vld_q <= 1'b0;
      end else if (fsm_q == IDLE && in_valid && !cache_hit) begin
         cache_key_q <= key_in;
         cache_vld_q <= 1'b0;
      end else if (fsm_q == KEXP && rnd_q == 4'(NR)) begin
         cache_rk_q  <= fwd_rk;
         cache_vld_q <= 1'b1;
      end
   end
`else
   assign cache_hit = 1'b0;
   assign hit_rk    = '0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) fsm_q <= IDLE;
      else        fsm_q <= fsm_d;
   end

   always_comb begin
      fsm_d     = fsm_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b1;
      case (fsm_q)
         IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid) fsm_d = cache_hit ? ROUND : KEXP;
         end
         KEXP:  if (rnd_q == 4'(NR)) fsm_d = ROUND;
         ROUND: if (rnd_q == 4'd0) fsm_d = DONE;
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) fsm_d = IDLE;
         end
         default: fsm_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blk_q <= '0;
         key_q <= '0;
         pt_q  <= '0;
         rnd_q <= '0;
      end else begin
         case (fsm_q)
            IDLE: begin
               if (in_valid) begin
                  if (cache_hit) begin
                     blk_q <= ct_in ^ hit_rk;
                     key_q <= hit_rk;
                     rnd_q <= 4'(NR - 1);
                  end else begin
                     blk_q <= ct_in;
                     key_q <= key_in;
                     rnd_q <= 4'd1;
                  end
               end
            end
            KEXP: begin
               key_q <= fwd_rk;
               if (rnd_q == 4'(NR)) begin
                  blk_q <= blk_q ^ fwd_rk;
                  rnd_q <= 4'(NR - 1);
               end else begin
                  rnd_q <= rnd_q + 4'd1;
               end
            end
            ROUND: begin
               key_q <= inv_rk;
               blk_q <= round_out;
               if (rnd_q == 4'd0) pt_q <= round_out;
               else               rnd_q <= rnd_q - 4'd1;
            end
            default: ;
         endcase
      end
   end

   assign pt_out = pt_q;

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Directed bench for aes_inv_cipher_iter using FIPS-197 vectors; honours AES_INV_KEY_CACHE_EN.
module tb_aes_inv_cipher_iter;

   localparam logic [127:0] C1_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1_CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] C1_PT   = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C1_RK10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
   localparam logic [127:0] B_KEY   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] B_CT    = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] B_PT    = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] B_RK10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
`ifdef AES_INV_KEY_CACHE_EN
   localparam int HIT_LAT = 11;
`else
   localparam int HIT_LAT = 21;
`endif

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] ct_in;
   logic [127:0] key_in;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] pt_out;
   logic         busy;

   int checks = 0;
   int errors = 0;

   aes_inv_cipher_iter #(.NR(10)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .ct_in     (ct_in),
      .key_in    (key_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .pt_out    (pt_out),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   // Returns at the falling edge of cycle T+1 with in_valid dropped.
   task automatic launch(input logic [127:0] ct, input logic [127:0] key);
      @(negedge clk);
      in_valid = 1'b1;
      ct_in    = ct;
      key_in   = key;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      ct_in    = '1;
      key_in   = '0;
   endtask

   // lat is the cycle index relative to T at which out_valid is first seen.
   task automatic wait_out(output int lat, output logic [127:0] rk10);
      lat  = 1;
      rk10 = '0;
      while (out_valid !== 1'b1 && lat < 200) begin
         @(negedge clk);
         lat++;
         if (lat == 11) rk10 = dut.key_q;
      end
   endtask

   task automatic ack;
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset;
      #2;
      checks++;
      if ({in_ready, out_valid, busy} !== 3'b100) begin
         errors++;
         $display("FAIL reset_flags got %b exp 100", {in_ready, out_valid, busy});
      end
      checks++;
      if (pt_out !== '0) begin
         errors++;
         $display("FAIL reset_pt got %h exp 0", pt_out);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_c1;
      int lat;
      logic [127:0] rk10;
      launch(C1_CT, C1_KEY);
      checks++;
      if ({in_ready, busy} !== 2'b01) begin
         errors++;
         $display("FAIL c1_busy got %b exp 01", {in_ready, busy});
      end
      wait_out(lat, rk10);
      checks++;
      if (lat !== 21) begin errors++; $display("FAIL c1_latency got %0d exp 21", lat); end
      checks++;
      if (pt_out !== C1_PT) begin errors++; $display("FAIL c1_pt got %h exp %h", pt_out, C1_PT); end
      checks++;
      if (rk10 !== C1_RK10) begin errors++; $display("FAIL c1_rk10 got %h exp %h", rk10, C1_RK10); end
      ack;
      checks++;
      if ({in_ready, out_valid, busy} !== 3'b100) begin
         errors++;
         $display("FAIL c1_idle got %b exp 100", {in_ready, out_valid, busy});
      end
   endtask

   task automatic test_appb;
      int lat;
      logic [127:0] rk10;
      launch(B_CT, B_KEY);
      wait_out(lat, rk10);
      checks++;
      if (lat !== 21) begin errors++; $display("FAIL appb_latency got %0d exp 21", lat); end
      checks++;
      if (pt_out !== B_PT) begin errors++; $display("FAIL appb_pt got %h exp %h", pt_out, B_PT); end
      checks++;
      if (rk10 !== B_RK10) begin errors++; $display("FAIL appb_rk10 got %h exp %h", rk10, B_RK10); end
      ack;
   endtask

   task automatic test_reset_mid;
      int lat;
      logic [127:0] rk10;
      launch(C1_CT, C1_KEY);
      repeat (11) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if ({in_ready, out_valid, busy} !== 3'b100) begin
         errors++;
         $display("FAIL abort_flags got %b exp 100", {in_ready, out_valid, busy});
      end
      checks++;
      if (pt_out !== '0) begin errors++; $display("FAIL abort_pt got %h exp 0", pt_out); end
      @(negedge clk);
      rst_n = 1'b1;
      launch(B_CT, B_KEY);
      wait_out(lat, rk10);
      checks++;
      if (lat !== 21) begin errors++; $display("FAIL post_abort_latency got %0d exp 21", lat); end
      checks++;
      if (pt_out !== B_PT) begin errors++; $display("FAIL post_abort_pt got %h exp %h", pt_out, B_PT); end
      ack;
   endtask

   task automatic test_back_to_back;
      int lat;
      logic [127:0] rk10;
      launch(C1_CT, C1_KEY);
      wait_out(lat, rk10);
      checks++;
      if (lat !== 21) begin errors++; $display("FAIL b2b_first_latency got %0d exp 21", lat); end
      ack;
      launch(C1_CT, C1_KEY);
      wait_out(lat, rk10);
      checks++;
      if (lat !== HIT_LAT) begin errors++; $display("FAIL b2b_second_latency got %0d exp %0d", lat, HIT_LAT); end
      checks++;
      if (pt_out !== C1_PT) begin errors++; $display("FAIL b2b_second_pt got %h exp %h", pt_out, C1_PT); end
      ack;
      launch(B_CT, B_KEY);
      wait_out(lat, rk10);
      checks++;
      if (lat !== 21) begin errors++; $display("FAIL b2b_miss_latency got %0d exp 21", lat); end
      checks++;
      if (pt_out !== B_PT) begin errors++; $display("FAIL b2b_miss_pt got %h exp %h", pt_out, B_PT); end
      ack;
   endtask

   task automatic test_backpressure;
      int lat;
      logic [127:0] rk10;
      launch(C1_CT, C1_KEY);
      wait_out(lat, rk10);
      checks++;
      if (lat !== 21) begin errors++; $display("FAIL bp_latency got %0d exp 21", lat); end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if ({out_valid, in_ready, busy} !== 3'b101 || pt_out !== C1_PT) begin
            errors++;
            $display("FAIL bp_hold cycle %0d got flags %b pt %h exp flags 101 pt %h",
                     i, {out_valid, in_ready, busy}, pt_out, C1_PT);
         end
      end
      ack;
      checks++;
      if ({in_ready, out_valid, busy} !== 3'b100) begin
         errors++;
         $display("FAIL bp_release got %b exp 100", {in_ready, out_valid, busy});
      end
   endtask

   task automatic test_done_ignore;
      int lat;
      logic [127:0] rk10;
      launch(B_CT, B_KEY);
      wait_out(lat, rk10);
      in_valid = 1'b1;
      key_in   = C1_KEY;
      for (int i = 0; i < 4; i++) begin
         ct_in = {$urandom, $urandom, $urandom, $urandom};
         @(negedge clk);
         checks++;
         if ({out_valid, in_ready} !== 2'b10 || pt_out !== B_PT) begin
            errors++;
            $display("FAIL done_hold cycle %0d got flags %b pt %h exp flags 10 pt %h",
                     i, {out_valid, in_ready}, pt_out, B_PT);
         end
      end
      ct_in = C1_CT;
      ack;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL done_reidle got %b exp 1", in_ready); end
      @(posedge clk);
      @(negedge clk);
      ct_in  = B_CT;
      key_in = B_KEY;
      checks++;
      if ({in_ready, busy} !== 2'b01) begin
         errors++;
         $display("FAIL done_accept got %b exp 01", {in_ready, busy});
      end
      wait_out(lat, rk10);
      in_valid = 1'b0;
      checks++;
      if (lat !== 21) begin errors++; $display("FAIL held_valid_latency got %0d exp 21", lat); end
      checks++;
      if (pt_out !== C1_PT) begin errors++; $display("FAIL held_valid_pt got %h exp %h", pt_out, C1_PT); end
      checks++;
      if (rk10 !== C1_RK10) begin errors++; $display("FAIL held_valid_rk10 got %h exp %h", rk10, C1_RK10); end
      ack;
      checks++;
      if ({in_ready, busy} !== 2'b10) begin
         errors++;
         $display("FAIL held_valid_idle got %b exp 10", {in_ready, busy});
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      ct_in     = '0;
      key_in    = '0;
      out_ready = 1'b0;
      test_reset;
      test_c1;
      test_appb;
      test_reset_mid;
      test_back_to_back;
      test_backpressure;
      test_done_ignore;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
